// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if: bundles the router controller's handshake, status and
// state-decode signals.
//   NUM_CH  number of destination channels
//   ADDR_W  header address field width
// Modports:
//   slave  - controller side: consumes source/FIFO status, drives decodes
//   master - environment side: drives source/FIFO status, observes decodes
interface router_fsm_nch_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_pkt_valid;

    logic [ADDR_W-1:0] dest_sel;
    logic              write_enb_reg;
    logic              detect_addr;
    logic              ld_state;
    logic              laf_state;
    logic              lfd_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              busy;
    logic              drop_pkt;
    logic              wait_timeout;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        output dest_sel, write_enb_reg, detect_addr, ld_state, laf_state,
               lfd_state, full_state, rst_int_reg, busy, drop_pkt,
               wait_timeout
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        input  dest_sel, write_enb_reg, detect_addr, ld_state, laf_state,
               lfd_state, full_state, rst_int_reg, busy, drop_pkt,
               wait_timeout
    );
endinterface

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: controller FSM for a 1xN packet router. Decodes the header
// address, sequences header/payload/parity writes into the selected output
// FIFO, stalls on full / not-empty destinations, drops packets addressed to
// non-existent channels and honours per-channel soft resets.
// Optional macro ROUTER_FSM_WAIT_TIMEOUT_EN: bounds WAIT_TILL_EMPTY to
// WAIT_LIMIT cycles, then drops the packet and pulses wait_timeout.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   bus    - router_fsm_nch_if.slave (source/FIFO status in, decodes out)
module router_fsm_nch #(
    parameter int NUM_CH     = 3,
    parameter int ADDR_W     = 2,
    parameter int WAIT_LIMIT = 64
) (
    input  logic              clk,
    input  logic              resetn,
    router_fsm_nch_if.slave   bus
);
    localparam int unsigned SPAN = 2 ** ADDR_W;

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("router_fsm_nch: NUM_CH must be 2..16");
    end
    if (SPAN < NUM_CH) begin : g_bad_addr_w
        $error("router_fsm_nch: 2**ADDR_W must cover NUM_CH");
    end
    if (WAIT_LIMIT < 1) begin : g_bad_wait_limit
        $error("router_fsm_nch: WAIT_LIMIT must be at least 1");
    end

    typedef enum logic [3:0] {
        S_DECODE_ADDRESS     = 4'd0,
        S_LOAD_FIRST_DATA    = 4'd1,
        S_LOAD_DATA          = 4'd2,
        S_FIFO_FULL_STATE    = 4'd3,
        S_LOAD_AFTER_FULL    = 4'd4,
        S_LOAD_PARITY        = 4'd5,
        S_CHECK_PARITY_ERROR = 4'd6,
        S_WAIT_TILL_EMPTY    = 4'd7,
        S_DROP_DATA          = 4'd8,
        S_DROP_PARITY        = 4'd9
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] dest_sel_q, dest_sel_d;

    // Per-channel vectors widened to the full address span so any header
    // value indexes safely; channels beyond NUM_CH read as absent.
    logic [SPAN-1:0] empty_ext, srst_ext, ch_ok_ext;

    always_comb begin
        empty_ext              = '0;
        srst_ext               = '0;
        ch_ok_ext              = '0;
        empty_ext[NUM_CH-1:0]  = bus.fifo_empty;
        srst_ext[NUM_CH-1:0]   = bus.soft_reset;
        ch_ok_ext[NUM_CH-1:0]  = '1;
    end

    logic srst_hit;
    assign srst_hit = srst_ext[dest_sel_q] &&
                      !(state_q inside {S_DECODE_ADDRESS, S_DROP_DATA, S_DROP_PARITY});

    logic timeout_hit;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // The empty flag wins a tie with the limit.
    assign timeout_hit = (state_q == S_WAIT_TILL_EMPTY) &&
                         (wait_cnt_q == CNT_W'(WAIT_LIMIT)) &&
                         !empty_ext[dest_sel_q];

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q != S_WAIT_TILL_EMPTY && state_d == S_WAIT_TILL_EMPTY) begin
            wait_cnt_d = '0;
        end else if (state_q == S_WAIT_TILL_EMPTY &&
                     wait_cnt_q != CNT_W'(WAIT_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.wait_timeout = timeout_hit && !srst_hit;
`else
    assign timeout_hit      = 1'b0;
    assign bus.wait_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        unique case (state_q)
            S_DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    dest_sel_d = bus.data_in;
                    if (!ch_ok_ext[bus.data_in]) begin
                        state_d = S_DROP_DATA;
                    end else if (empty_ext[bus.data_in]) begin
                        state_d = S_LOAD_FIRST_DATA;
                    end else begin
                        state_d = S_WAIT_TILL_EMPTY;
                    end
                end
            end
            S_LOAD_FIRST_DATA: state_d = S_LOAD_DATA;
            S_LOAD_DATA: begin
                if (bus.fifo_full) begin
                    state_d = S_FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    state_d = S_LOAD_PARITY;
                end
            end
            S_FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_d = S_LOAD_AFTER_FULL;
            end
            S_LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    state_d = S_DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    state_d = S_LOAD_PARITY;
                end else begin
                    state_d = S_LOAD_DATA;
                end
            end
            S_LOAD_PARITY: state_d = S_CHECK_PARITY_ERROR;
            S_CHECK_PARITY_ERROR: begin
                state_d = bus.fifo_full ? S_FIFO_FULL_STATE : S_DECODE_ADDRESS;
            end
            S_WAIT_TILL_EMPTY: begin
                if (empty_ext[dest_sel_q]) begin
                    state_d = S_LOAD_FIRST_DATA;
                end else if (timeout_hit) begin
                    state_d = S_DROP_DATA;
                end
            end
            S_DROP_DATA: begin
                if (!bus.pkt_valid) state_d = S_DROP_PARITY;
            end
            S_DROP_PARITY: state_d = S_DECODE_ADDRESS;
            default: state_d = S_DECODE_ADDRESS;
        endcase
        if (srst_hit) state_d = S_DECODE_ADDRESS;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_DECODE_ADDRESS;
            dest_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            dest_sel_q <= dest_sel_d;
        end
    end

    assign bus.dest_sel      = dest_sel_q;
    assign bus.detect_addr   = (state_q == S_DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == S_LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == S_LOAD_DATA);
    assign bus.full_state    = (state_q == S_FIFO_FULL_STATE);
    assign bus.laf_state     = (state_q == S_LOAD_AFTER_FULL);
    assign bus.rst_int_reg   = (state_q == S_CHECK_PARITY_ERROR);
    assign bus.drop_pkt      = (state_q inside {S_DROP_DATA, S_DROP_PARITY});
    assign bus.write_enb_reg = (state_q inside {S_LOAD_DATA, S_LOAD_AFTER_FULL,
                                                S_LOAD_PARITY});
    assign bus.busy          = (state_q inside {S_LOAD_FIRST_DATA, S_FIFO_FULL_STATE,
                                                S_LOAD_AFTER_FULL, S_LOAD_PARITY,
                                                S_CHECK_PARITY_ERROR,
                                                S_WAIT_TILL_EMPTY});
endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: directed, self-checking bench for router_fsm_nch with
// NUM_CH=3, ADDR_W=2, WAIT_LIMIT=8. Follows ROUTER_FSM_WAIT_TIMEOUT_EN in
// the same way as the design.
module tb_router_fsm_nch;
    logic clk;
    logic resetn;

    router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

    router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_LIMIT(8)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed decode vector:
    // {detect, lfd, ld, laf, full, rst_int, busy, write_enb, drop, wait_timeout}
    logic [9:0] obs;
    assign obs = {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state,
                  bus.full_state, bus.rst_int_reg, bus.busy, bus.write_enb_reg,
                  bus.drop_pkt, bus.wait_timeout};

    localparam logic [9:0] DEC = 10'b1000000000;
    localparam logic [9:0] LFD = 10'b0100001000;
    localparam logic [9:0] LD  = 10'b0010000100;
    localparam logic [9:0] LAF = 10'b0001001100;
    localparam logic [9:0] FUL = 10'b0000101000;
    localparam logic [9:0] LP  = 10'b0000001100;
    localparam logic [9:0] CPE = 10'b0000011000;
    localparam logic [9:0] WTE = 10'b0000001000;
    localparam logic [9:0] DRP = 10'b0000000010;
    localparam logic [9:0] TMO = 10'b0000001001;

    typedef struct packed {
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] empty;
        logic [2:0] srst;
        logic       pd;
        logic       lpv;
        logic [9:0] exp;
    } step_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic drive(input step_t s);
        bus.pkt_valid     = s.pv;
        bus.data_in       = s.din;
        bus.fifo_full     = s.full;
        bus.fifo_empty    = s.empty;
        bus.soft_reset    = s.srst;
        bus.parity_done   = s.pd;
        bus.low_pkt_valid = s.lpv;
    endtask

    task automatic test_reset();
        drive('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DEC});
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (obs !== DEC) $display("FAIL reset_state: got %b want %b", obs, DEC);
        else n_pass++;
        n_chk++;
        if (bus.dest_sel !== 2'd0) $display("FAIL reset_dest: got %0d want 0", bus.dest_sel);
        else n_pass++;
        resetn = 1'b1;
    endtask

    task automatic test_basic_packet();
        step_t t [6] = '{
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD},
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LP },
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, CPE},
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DEC}
        };
        for (int i = 0; i < 6; i++) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            n_chk++;
            if (obs !== t[i].exp) $display("FAIL basic step %0d: got %b want %b", i, obs, t[i].exp);
            else n_pass++;
        end
        n_chk++;
        if (bus.dest_sel !== 2'd0) $display("FAIL basic_dest: got %0d want 0", bus.dest_sel);
        else n_pass++;
    endtask

    task automatic test_wait_empty();
        step_t t [11] = '{
            '{1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD},
            '{1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LP },
            '{1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, CPE},
            '{1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DEC}
        };
        for (int i = 0; i < 11; i++) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            n_chk++;
            if (obs !== t[i].exp) $display("FAIL wait_empty step %0d: got %b want %b", i, obs, t[i].exp);
            else n_pass++;
        end
        n_chk++;
        if (bus.dest_sel !== 2'd1) $display("FAIL wait_dest: got %0d want 1", bus.dest_sel);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        step_t t [8] = '{
            '{1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD},
            '{1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b1, 2'd2, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FUL},
            '{1'b1, 2'd2, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FUL},
            '{1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, LAF},
            '{1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, LP },
            '{1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, CPE},
            '{1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DEC}
        };
        for (int i = 0; i < 8; i++) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            n_chk++;
            if (obs !== t[i].exp) $display("FAIL fifo_full step %0d: got %b want %b", i, obs, t[i].exp);
            else n_pass++;
        end
        n_chk++;
        if (bus.dest_sel !== 2'd2) $display("FAIL full_dest: got %0d want 2", bus.dest_sel);
        else n_pass++;
    endtask

    task automatic test_laf_paths();
        step_t t [15] = '{
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD},
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FUL},
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LAF},
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FUL},
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LAF},
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, DEC},
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD},
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LP },
            '{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, CPE},
            '{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FUL},
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LAF},
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, DEC}
        };
        for (int i = 0; i < 15; i++) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            n_chk++;
            if (obs !== t[i].exp) $display("FAIL laf_paths step %0d: got %b want %b", i, obs, t[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        step_t t [7] = '{
            '{1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DRP},
            '{1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DRP},
            '{1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DRP},
            '{1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DRP},
            '{1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DRP},
            '{1'b0, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DRP},
            '{1'b0, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DEC}
        };
        for (int i = 0; i < 7; i++) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            n_chk++;
            if (obs !== t[i].exp) $display("FAIL drop step %0d: got %b want %b", i, obs, t[i].exp);
            else n_pass++;
        end
        n_chk++;
        if (bus.dest_sel !== 2'd3) $display("FAIL drop_dest: got %0d want 3", bus.dest_sel);
        else n_pass++;
    endtask

    task automatic test_soft_reset();
        step_t t [7] = '{
            '{1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD},
            '{1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b1, 2'd1, 1'b0, 3'b111, 3'b100, 1'b0, 1'b0, LD },
            '{1'b0, 2'd1, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, DEC},
            '{1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd2, 1'b0, 3'b011, 3'b001, 1'b0, 1'b0, WTE},
            '{1'b0, 2'd2, 1'b0, 3'b011, 3'b100, 1'b0, 1'b0, DEC}
        };
        for (int i = 0; i < 7; i++) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            n_chk++;
            if (obs !== t[i].exp) $display("FAIL soft_reset step %0d: got %b want %b", i, obs, t[i].exp);
            else n_pass++;
            if (i == 3) begin
                n_chk++;
                if (bus.dest_sel !== 2'd1) $display("FAIL srst_dest_kept: got %0d want 1", bus.dest_sel);
                else n_pass++;
            end
        end
        bus.soft_reset = 3'b000;
    endtask

    task automatic test_async_reset();
        step_t t [3] = '{
            '{1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD},
            '{1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b1, 2'd2, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FUL}
        };
        for (int i = 0; i < 3; i++) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            n_chk++;
            if (obs !== t[i].exp) $display("FAIL async_reset step %0d: got %b want %b", i, obs, t[i].exp);
            else n_pass++;
        end
        #2;
        resetn = 1'b0;
        #1;
        n_chk++;
        if (obs !== DEC) $display("FAIL async_reset_now: got %b want %b", obs, DEC);
        else n_pass++;
        n_chk++;
        if (bus.dest_sel !== 2'd0) $display("FAIL async_reset_dest: got %0d want 0", bus.dest_sel);
        else n_pass++;
        drive('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DEC});
        @(posedge clk);
        #1;
        resetn = 1'b1;
        n_chk++;
        if (obs !== DEC) $display("FAIL async_reset_hold: got %b want %b", obs, DEC);
        else n_pass++;
    endtask

    task automatic test_wait_timeout();
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        localparam int N = 12;
        step_t t [N] = '{
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, TMO},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, DRP},
            '{1'b0, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, DRP},
            '{1'b0, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, DEC}
        };
`else
        localparam int N = 17;
        step_t t [N] = '{
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, WTE},
            '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD},
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD },
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LP },
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, CPE},
            '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DEC}
        };
`endif
        for (int i = 0; i < N; i++) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            n_chk++;
            if (obs !== t[i].exp) $display("FAIL wait_timeout step %0d: got %b want %b", i, obs, t[i].exp);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_packet();
        test_wait_empty();
        test_fifo_full();
        test_laf_paths();
        test_drop();
        test_soft_reset();
        test_async_reset();
        test_wait_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
